// File: rtl/mux_scan_nto1_if.sv
// Bundles the channel inputs, select/mode/enable controls and the registered selection outputs.
// Latency: none; this is wiring only.
// Backpressure: none; the en signal carried here is the only stall control.
interface mux_scan_nto1_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = (N > 2) ? $clog2(N) : 1;

    logic [N*W-1:0] din;
    logic [SW-1:0]  sel;
    logic           mode;
    logic           en;
    logic [W-1:0]   y;
    logic [SW-1:0]  ch;
    logic           valid;
    logic           wrap;

    // Stimulus side: drives data and controls, observes the selection.
    modport master (
        output din, sel, mode, en,
        input  y, ch, valid, wrap
    );

    // Mux side: consumes data and controls, produces the selection.
    modport slave (
        input  din, sel, mode, en,
        output y, ch, valid, wrap
    );
endinterface

// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 mux with manual select and automatic dwell-based channel scan.
// Latency: one cycle from din/sel/mode at an edge to y/ch/valid/wrap after that edge.
// Backpressure: none; en=0 freezes all state and outputs, and forces wrap low.
module mux_scan_nto1 #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_nto1_if.slave  bus
);
    localparam int SW = (N > 2) ? $clog2(N) : 1;
    localparam int DW = $clog2(DWELL) + 1;

    localparam logic [SW-1:0] P_LAST = SW'(N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] p;
    logic [DW-1:0] d;

    logic [W-1:0]  y_q;
    logic [SW-1:0] ch_q;
    logic          valid_q;
    logic          wrap_q;

    // Pointer and dwell as seen by a scan edge: a scan entered from IDLE or
    // MANUAL always begins at channel 0 with a fresh dwell.
    logic [SW-1:0] scan_p;
    logic [DW-1:0] scan_d;
    logic [W-1:0]  man_dat;
    logic          man_ok;
    logic [W-1:0]  scan_dat;

    assign scan_p = (state == ST_SCAN) ? p : '0;
    assign scan_d = (state == ST_SCAN) ? d : '0;

    // Channel selection for both modes; out-of-range manual selects leave man_ok low.
    always_comb begin
        man_dat  = '0;
        man_ok   = 1'b0;
        scan_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.sel == SW'(k)) begin
                man_dat = bus.din[k*W +: W];
                man_ok  = 1'b1;
            end
            if (scan_p == SW'(k)) begin
                scan_dat = bus.din[k*W +: W];
            end
        end
    end

    // Mode FSM, scan pointer/dwell counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            p       <= '0;
            d       <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (!bus.en) begin
            wrap_q <= 1'b0;
        end else if (!bus.mode) begin
            state   <= ST_MANUAL;
            y_q     <= man_ok ? man_dat : '0;
            ch_q    <= bus.sel;
            valid_q <= man_ok;
            wrap_q  <= 1'b0;
            p       <= '0;
            d       <= '0;
        end else begin
            state   <= ST_SCAN;
            y_q     <= scan_dat;
            ch_q    <= scan_p;
            valid_q <= 1'b1;
            if (scan_d == D_LAST) begin
                d      <= '0;
                p      <= (scan_p == P_LAST) ? '0 : scan_p + 1'b1;
                wrap_q <= (scan_p == P_LAST);
            end else begin
                d      <= scan_d + 1'b1;
                wrap_q <= 1'b0;
            end
        end
    end

    assign bus.y     = y_q;
    assign bus.ch    = ch_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-count model.
// Latency: outputs are checked 1 time unit after each rising edge.
// Backpressure: en is toggled to exercise stalls.
module tb_mux_scan_nto1;
    localparam int N1 = 4;
    localparam int D1 = 3;
    localparam logic [31:0] DIN1 = 32'hD3C2B1A0;
    localparam logic [11:0] DIN2 = 12'hC74;

    logic clk = 1'b0;
    logic rst1, rst2;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_scan_nto1_if #(.N(4), .W(8)) i1 ();
    mux_scan_nto1_if #(.N(3), .W(4)) i2 ();

    mux_scan_nto1 #(.N(4), .W(8), .DWELL(3)) dut1 (.clk(clk), .rst(rst1), .bus(i1));
    mux_scan_nto1 #(.N(3), .W(4), .DWELL(2)) dut2 (.clk(clk), .rst(rst2), .bus(i2));

    // Reference model: scan position is a plain count of enabled scan edges.
    logic [7:0] m_y;
    logic [1:0] m_ch;
    logic       m_valid, m_wrap;
    int         m_k;

    task automatic model_update();
        int c;
        if (rst1) begin
            m_y = 0; m_ch = 0; m_valid = 0; m_wrap = 0; m_k = 0;
        end else if (!i1.en) begin
            m_wrap = 0;
        end else if (!i1.mode) begin
            m_y = i1.din[int'(i1.sel)*8 +: 8];
            m_ch = i1.sel; m_valid = 1; m_wrap = 0; m_k = 0;
        end else begin
            c = (m_k / D1) % N1;
            m_y = i1.din[c*8 +: 8];
            m_ch = 2'(c); m_valid = 1;
            m_wrap = ((m_k % (N1*D1)) == N1*D1 - 1);
            m_k++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic md, input logic [1:0] s);
        rst1 = r; i1.en = e; i1.mode = md; i1.sel = s;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0);
        i1.din = DIN1;
        tick();
        total++;
        if ({i1.y, i1.ch, i1.valid, i1.wrap} !== 12'h0) begin
            bad++; $display("FAIL reset: got y=%h ch=%0d v=%b w=%b want 0", i1.y, i1.ch, i1.valid, i1.wrap);
        end
        drive(0, 0, 1, 0);
        tick();
        total++;
        if ({i1.y, i1.ch, i1.valid, i1.wrap} !== 12'h0) begin
            bad++; $display("FAIL idle_hold: got y=%h ch=%0d v=%b w=%b want 0", i1.y, i1.ch, i1.valid, i1.wrap);
        end
    endtask

    task automatic test_manual();
        logic [7:0] exp_y [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        for (int s = 0; s < 4; s++) begin
            drive(0, 1, 0, 2'(s));
            tick();
            total++;
            if (i1.y !== exp_y[s] || i1.ch !== 2'(s) || i1.valid !== 1'b1 || i1.wrap !== 1'b0) begin
                bad++; $display("FAIL manual sel=%0d: got y=%h ch=%0d v=%b w=%b want y=%h", s, i1.y, i1.ch, i1.valid, i1.wrap, exp_y[s]);
            end
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp_y [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        for (int i = 0; i < 13; i++) begin
            drive(0, 1, 1, 0);
            tick();
            total++;
            if (i1.y !== exp_y[(i/3)%4] || i1.ch !== 2'((i/3)%4) || i1.valid !== 1'b1 || i1.wrap !== (i == 11)) begin
                bad++; $display("FAIL scan cyc=%0d: got y=%h ch=%0d w=%b want y=%h ch=%0d w=%b", i, i1.y, i1.ch, i1.wrap, exp_y[(i/3)%4], (i/3)%4, i == 11);
            end
        end
    endtask

    task automatic test_stall();
        drive(1, 1, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin drive(0, 1, 1, 0); tick(); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0); tick();
            total++;
            if (i1.y !== 8'hB1 || i1.ch !== 2'd1 || i1.valid !== 1'b1 || i1.wrap !== 1'b0) begin
                bad++; $display("FAIL stall cyc=%0d: got y=%h ch=%0d w=%b want y=b1 ch=1 w=0", i, i1.y, i1.ch, i1.wrap);
            end
        end
        drive(0, 1, 1, 0); tick();
        total++;
        if (i1.y !== 8'hB1 || i1.ch !== 2'd1) begin
            bad++; $display("FAIL stall_resume: got y=%h ch=%0d want y=b1 ch=1", i1.y, i1.ch);
        end
        tick();
        total++;
        if (i1.y !== 8'hC2 || i1.ch !== 2'd2) begin
            bad++; $display("FAIL stall_next: got y=%h ch=%0d want y=c2 ch=2", i1.y, i1.ch);
        end
    endtask

    task automatic test_mode_switch();
        drive(1, 1, 0, 0); tick();
        for (int i = 0; i < 7; i++) begin drive(0, 1, 1, 0); tick(); end
        drive(0, 1, 0, 2); tick();
        total++;
        if (i1.y !== 8'hC2 || i1.ch !== 2'd2 || i1.valid !== 1'b1 || i1.wrap !== 1'b0) begin
            bad++; $display("FAIL switch_to_manual: got y=%h ch=%0d want y=c2 ch=2", i1.y, i1.ch);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0); tick();
            total++;
            if (i1.y !== ((i < 3) ? 8'hA0 : 8'hB1) || i1.ch !== ((i < 3) ? 2'd0 : 2'd1)) begin
                bad++; $display("FAIL switch_to_scan cyc=%0d: got y=%h ch=%0d want y=%h", i, i1.y, i1.ch, (i < 3) ? 8'hA0 : 8'hB1);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        drive(1, 1, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin drive(0, 1, 1, 0); tick(); end
        total++;
        if (i1.y !== 8'hD3) begin
            bad++; $display("FAIL pre_reset_dwell: got y=%h want d3", i1.y);
        end
        drive(1, 1, 1, 0); tick();
        total++;
        if ({i1.y, i1.ch, i1.valid, i1.wrap} !== 12'h0) begin
            bad++; $display("FAIL reset_mid_scan: got y=%h ch=%0d v=%b w=%b want 0", i1.y, i1.ch, i1.valid, i1.wrap);
        end
        drive(0, 1, 1, 0); tick();
        total++;
        if (i1.y !== 8'hA0 || i1.ch !== 2'd0 || i1.valid !== 1'b1) begin
            bad++; $display("FAIL restart_scan: got y=%h ch=%0d v=%b want y=a0 ch=0 v=1", i1.y, i1.ch, i1.valid);
        end
    endtask

    task automatic test_random();
        drive(1, 1, 0, 0); tick();
        for (int i = 0; i < 400; i++) begin
            rst1    = ($urandom_range(0, 99) < 3);
            i1.en   = ($urandom_range(0, 99) < 80);
            i1.mode = ($urandom_range(0, 99) < 75);
            i1.sel  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 30) i1.din = $urandom;
            tick();
            total++;
            if (i1.y !== m_y || i1.ch !== m_ch || i1.valid !== m_valid || i1.wrap !== m_wrap) begin
                bad++; $display("FAIL random cyc=%0d: got y=%h ch=%0d v=%b w=%b want y=%h ch=%0d v=%b w=%b",
                                i, i1.y, i1.ch, i1.valid, i1.wrap, m_y, m_ch, m_valid, m_wrap);
            end
        end
    endtask

    task automatic test_n3();
        logic [3:0] ey;
        rst2 = 1; i2.en = 1; i2.mode = 0; i2.sel = 0; i2.din = DIN2;
        @(posedge clk); #1;
        rst2 = 0;
        for (int s = 3; s >= 0; s--) begin
            i2.sel = 2'(s);
            @(posedge clk); #1;
            ey = (s < 3) ? DIN2[s*4 +: 4] : 4'h0;
            total++;
            if (i2.y !== ey || i2.ch !== 2'(s) || i2.valid !== (s < 3) || i2.wrap !== 1'b0) begin
                bad++; $display("FAIL n3_manual sel=%0d: got y=%h ch=%0d v=%b want y=%h v=%b", s, i2.y, i2.ch, i2.valid, ey, s < 3);
            end
        end
        i2.mode = 1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            ey = DIN2[((i/2)%3)*4 +: 4];
            total++;
            if (i2.y !== ey || i2.ch !== 2'((i/2)%3) || i2.wrap !== (i == 5)) begin
                bad++; $display("FAIL n3_scan cyc=%0d: got y=%h ch=%0d w=%b want y=%h ch=%0d w=%b", i, i2.y, i2.ch, i2.wrap, ey, (i/2)%3, i == 5);
            end
        end
    endtask

    initial begin
        rst1 = 1; rst2 = 1;
        i1.din = DIN1; i1.sel = 0; i1.mode = 0; i1.en = 0;
        i2.din = DIN2; i2.sel = 0; i2.mode = 0; i2.en = 0;
        m_y = 0; m_ch = 0; m_valid = 0; m_wrap = 0; m_k = 0;
        #2;
        test_reset();
        test_manual();
        test_scan();
        test_stall();
        test_mode_switch();
        test_reset_mid_scan();
        test_n3();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
